// File: rtl/loop_ro_mux_if.sv
// Loop-decode bus between the instruction source (master) and loop_ro_mux (slave).
// Carries descriptor table, instruction fields and the packed decoded-loop word.
interface loop_ro_mux_if #(
  parameter int LOG_LOOP_CNT = 3,
  parameter int ITER_W       = 18,
  parameter int JUMP_W       = 6
);
  localparam int ENTRY_W  = ITER_W + JUMP_W;
  localparam int NUM_DESC = 1 << LOG_LOOP_CNT;
  localparam int INSTR_W  = 2 + LOG_LOOP_CNT + ENTRY_W;

  logic [LOG_LOOP_CNT-1:0]     addr;
  logic [NUM_DESC*ENTRY_W-1:0] in;
  logic                        independent;
  logic                        new_loop;
  logic [INSTR_W-1:0]          loop_instr;
  logic                        zero_iter_err;

  modport master (
    output addr, in, independent, new_loop,
    input  loop_instr, zero_iter_err
  );

  modport slave (
    input  addr, in, independent, new_loop,
    output loop_instr, zero_iter_err
  );
endinterface

// File: rtl/loop_ro_mux.sv
// Loop-instruction descriptor mux: picks descriptor[addr] and packs it with the flags.
// Optional output register enabled by defining LOOP_RO_MUX_REG_OUT_EN.
module loop_ro_mux #(
  parameter int LOG_LOOP_CNT = 3,
  parameter int ITER_W       = 18,
  parameter int JUMP_W       = 6
) (
  input  logic          clk,
  input  logic          reset,
  loop_ro_mux_if.slave  bus
);
  localparam int ENTRY_W = ITER_W + JUMP_W;
  localparam int INSTR_W = 2 + LOG_LOOP_CNT + ENTRY_W;

  logic [ENTRY_W-1:0] w_desc;
  logic [ITER_W-1:0]  w_iter;
  logic [JUMP_W-1:0]  w_jump;
  logic [INSTR_W-1:0] w_instr;
  logic               w_zero_err;

  // Fixed-slot selects keep every mux leg a constant part-select; an X addr yields X fields.
  always_comb begin
    w_desc = '0;
    case (bus.addr)
      3'd0:    w_desc = bus.in[0*ENTRY_W +: ENTRY_W];
      3'd1:    w_desc = bus.in[1*ENTRY_W +: ENTRY_W];
      3'd2:    w_desc = bus.in[2*ENTRY_W +: ENTRY_W];
      3'd3:    w_desc = bus.in[3*ENTRY_W +: ENTRY_W];
      3'd4:    w_desc = bus.in[4*ENTRY_W +: ENTRY_W];
      3'd5:    w_desc = bus.in[5*ENTRY_W +: ENTRY_W];
      3'd6:    w_desc = bus.in[6*ENTRY_W +: ENTRY_W];
      3'd7:    w_desc = bus.in[7*ENTRY_W +: ENTRY_W];
      default: w_desc = 'x;
    endcase
  end

  assign w_iter     = w_desc[ENTRY_W-1:JUMP_W];
  assign w_jump     = w_desc[JUMP_W-1:0];
  assign w_instr    = {bus.new_loop, bus.independent, bus.addr, w_iter, w_jump};
  assign w_zero_err = bus.new_loop & (w_iter == '0);

`ifdef LOOP_RO_MUX_REG_OUT_EN
  logic [INSTR_W-1:0] r_instr;
  logic               r_zero_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr    <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_instr    <= w_instr;
      r_zero_err <= w_zero_err;
    end
  end

  assign bus.loop_instr    = r_instr;
  assign bus.zero_iter_err = r_zero_err;
`else
  // Combinational build: clock and reset are intentionally unconnected to any logic.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ reset;

  assign bus.loop_instr    = w_instr;
  assign bus.zero_iter_err = w_zero_err;
`endif
endmodule

// File: tb/tb_loop_ro_mux.sv
// Directed bench for loop_ro_mux; covers both the combinational and registered builds.
module tb_loop_ro_mux;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  loop_ro_mux_if bus ();

  loop_ro_mux dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait until the decode for the currently driven inputs is visible on the outputs.
  task automatic settle();
`ifdef LOOP_RO_MUX_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic load_pattern();
    logic [191:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[k*24 +: 24] = {18'(k + 1), 6'(k + 2)};
    end
    bus.in = v;
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    load_pattern();
    bus.addr        = 3'd2;
    bus.new_loop    = 1'b1;
    bus.independent = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
`ifdef LOOP_RO_MUX_REG_OUT_EN
    if (bus.loop_instr !== 29'd0) begin
      bad++;
      $display("FAIL reset_instr: got %h want %h", bus.loop_instr, 29'd0);
    end
    total++;
    if (bus.zero_iter_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: got %b want %b", bus.zero_iter_err, 1'b0);
    end
`else
    if (bus.loop_instr !== {1'b1, 1'b0, 3'd2, 18'd3, 6'd4}) begin
      bad++;
      $display("FAIL reset_comb_instr: got %h want %h", bus.loop_instr, {1'b1, 1'b0, 3'd2, 18'd3, 6'd4});
    end
    total++;
    if (bus.zero_iter_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_comb_err: got %b want %b", bus.zero_iter_err, 1'b0);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    load_pattern();
    bus.addr        = 3'd5;
    bus.new_loop    = 1'b1;
    bus.independent = 1'b1;
    settle();
    total++;
    if (bus.loop_instr !== {1'b1, 1'b1, 3'd5, 18'd6, 6'd7}) begin
      bad++;
      $display("FAIL basic_instr: got %h want %h", bus.loop_instr, {1'b1, 1'b1, 3'd5, 18'd6, 6'd7});
    end
    total++;
    if (bus.zero_iter_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_err: got %b want %b", bus.zero_iter_err, 1'b0);
    end
  endtask

  task automatic test_max_desc();
    logic [191:0] v;
    load_pattern();
    v = bus.in;
    v[0 +: 24] = {18'h3FFFF, 6'h3F};
    bus.in          = v;
    bus.addr        = 3'd0;
    bus.new_loop    = 1'b0;
    bus.independent = 1'b0;
    settle();
    total++;
    if (bus.loop_instr !== {1'b0, 1'b0, 3'd0, 18'd262143, 6'd63}) begin
      bad++;
      $display("FAIL max_desc_instr: got %h want %h", bus.loop_instr, {1'b0, 1'b0, 3'd0, 18'd262143, 6'd63});
    end
    total++;
    if (bus.zero_iter_err !== 1'b0) begin
      bad++;
      $display("FAIL max_desc_err: got %b want %b", bus.zero_iter_err, 1'b0);
    end
  endtask

  task automatic test_zero_iter();
    logic [191:0] v;
    load_pattern();
    v = bus.in;
    v[7*24 +: 24] = 24'd0;
    v[6*24 +: 24] = {18'd0, 6'd5};
    v[4*24 +: 24] = {18'd1, 6'd0};
    bus.in          = v;
    bus.addr        = 3'd7;
    bus.new_loop    = 1'b1;
    bus.independent = 1'b0;
    settle();
    total++;
    if (bus.zero_iter_err !== 1'b1) begin
      bad++;
      $display("FAIL zero7_new_err: got %b want %b", bus.zero_iter_err, 1'b1);
    end
    total++;
    if (bus.loop_instr !== {1'b1, 1'b0, 3'd7, 18'd0, 6'd0}) begin
      bad++;
      $display("FAIL zero7_new_instr: got %h want %h", bus.loop_instr, {1'b1, 1'b0, 3'd7, 18'd0, 6'd0});
    end
    bus.new_loop = 1'b0;
    settle();
    total++;
    if (bus.zero_iter_err !== 1'b0) begin
      bad++;
      $display("FAIL zero7_end_err: got %b want %b", bus.zero_iter_err, 1'b0);
    end
    // Zero iterations with a nonzero jump still flags; a nonzero count with zero jump does not.
    bus.addr     = 3'd6;
    bus.new_loop = 1'b1;
    settle();
    total++;
    if (bus.zero_iter_err !== 1'b1) begin
      bad++;
      $display("FAIL zero6_jump_err: got %b want %b", bus.zero_iter_err, 1'b1);
    end
    bus.addr = 3'd4;
    settle();
    total++;
    if (bus.zero_iter_err !== 1'b0) begin
      bad++;
      $display("FAIL one4_err: got %b want %b", bus.zero_iter_err, 1'b0);
    end
    total++;
    if (bus.loop_instr !== {1'b1, 1'b0, 3'd4, 18'd1, 6'd0}) begin
      bad++;
      $display("FAIL one4_instr: got %h want %h", bus.loop_instr, {1'b1, 1'b0, 3'd4, 18'd1, 6'd0});
    end
  endtask

  task automatic test_indep_end_loop();
    load_pattern();
    bus.addr        = 3'd1;
    bus.new_loop    = 1'b0;
    bus.independent = 1'b1;
    settle();
    total++;
    if (bus.loop_instr !== {1'b0, 1'b1, 3'd1, 18'd2, 6'd3}) begin
      bad++;
      $display("FAIL indep_end_instr: got %h want %h", bus.loop_instr, {1'b0, 1'b1, 3'd1, 18'd2, 6'd3});
    end
  endtask

  task automatic test_sweep();
    logic [191:0] v;
    logic [23:0]  d;
    logic [28:0]  exp_instr;
    logic         exp_err;
    logic         nl;
    logic         ind;
    for (int w = 0; w < 6; w++) begin
      v[w*32 +: 32] = $urandom;
    end
    v[2*24 +: 18 + 6] = {18'd0, v[2*24 +: 6]};
    bus.in = v;
    for (int a = 0; a < 8; a++) begin
      nl  = 1'($urandom_range(0, 1));
      ind = 1'($urandom_range(0, 1));
      if (a == 2) nl = 1'b1;
      bus.addr        = 3'(a);
      bus.new_loop    = nl;
      bus.independent = ind;
      d         = v[a*24 +: 24];
      exp_instr = {nl, ind, 3'(a), d};
      exp_err   = nl && (d[23:6] == 18'd0);
      settle();
      total++;
      if (bus.loop_instr !== exp_instr) begin
        bad++;
        $display("FAIL sweep_instr a=%0d: got %h want %h", a, bus.loop_instr, exp_instr);
      end
      total++;
      if (bus.zero_iter_err !== exp_err) begin
        bad++;
        $display("FAIL sweep_err a=%0d: got %b want %b", a, bus.zero_iter_err, exp_err);
      end
    end
  endtask

  task automatic test_follow();
    logic [191:0] v;
    load_pattern();
    bus.addr        = 3'd3;
    bus.new_loop    = 1'b1;
    bus.independent = 1'b0;
    settle();
    total++;
    if (bus.loop_instr !== {1'b1, 1'b0, 3'd3, 18'd4, 6'd5}) begin
      bad++;
      $display("FAIL follow_init: got %h want %h", bus.loop_instr, {1'b1, 1'b0, 3'd3, 18'd4, 6'd5});
    end
    v = bus.in;
    v[3*24 +: 24] = {18'h2ABCD, 6'h15};
    bus.in = v;
    #1;
`ifdef LOOP_RO_MUX_REG_OUT_EN
    total++;
    if (bus.loop_instr !== {1'b1, 1'b0, 3'd3, 18'd4, 6'd5}) begin
      bad++;
      $display("FAIL follow_hold: got %h want %h", bus.loop_instr, {1'b1, 1'b0, 3'd3, 18'd4, 6'd5});
    end
    @(posedge clk);
    #1;
`endif
    total++;
    if (bus.loop_instr !== {1'b1, 1'b0, 3'd3, 18'h2ABCD, 6'h15}) begin
      bad++;
      $display("FAIL follow_new: got %h want %h", bus.loop_instr, {1'b1, 1'b0, 3'd3, 18'h2ABCD, 6'h15});
    end
  endtask

`ifdef LOOP_RO_MUX_REG_OUT_EN
  task automatic test_mid_reset();
    load_pattern();
    bus.addr        = 3'd6;
    bus.new_loop    = 1'b1;
    bus.independent = 1'b1;
    settle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.loop_instr !== 29'd0) begin
      bad++;
      $display("FAIL midreset_instr: got %h want %h", bus.loop_instr, 29'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (bus.loop_instr !== 29'd0) begin
      bad++;
      $display("FAIL release_hold: got %h want %h", bus.loop_instr, 29'd0);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.loop_instr !== {1'b1, 1'b1, 3'd6, 18'd7, 6'd8}) begin
      bad++;
      $display("FAIL release_load: got %h want %h", bus.loop_instr, {1'b1, 1'b1, 3'd6, 18'd7, 6'd8});
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_max_desc();
    test_zero_iter();
    test_indep_end_loop();
    test_sweep();
    test_follow();
`ifdef LOOP_RO_MUX_REG_OUT_EN
    test_mid_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
